// File: rtl/blink_pkg.sv
// Shared constants and FSM state type for the Blink stream loader.
// Field word offsets locate K0, K1, P and T inside the 76-word input frame.
package blink_pkg;

    localparam int unsigned N           = 128;
    localparam int unsigned TWEAK_LEN   = 256;
    localparam int unsigned ROUNDS      = 20;
    localparam int unsigned K0_W        = 1280;
    localparam int unsigned K1_W        = 766;
    localparam int unsigned FRAME_WORDS = 76;

    localparam int unsigned NW_K0 = 40;
    localparam int unsigned NW_K1 = 24;
    localparam int unsigned NW_P  = 4;
    localparam int unsigned NW_T  = 8;

    localparam logic [6:0] OFF_K0     = 7'd0;
    localparam logic [6:0] OFF_K1     = 7'd40;
    localparam logic [6:0] OFF_P      = 7'd64;
    localparam logic [6:0] OFF_T      = 7'd68;
    localparam logic [6:0] K1_TOP     = 7'd63;
    localparam logic [6:0] FRAME_LAST = 7'd75;

    typedef enum logic [1:0] {
        StLoad,
        StWait,
        StOut
    } state_e;

endpackage

// File: rtl/blink_stream_loader.sv
// Narrow-bus front end for the Blink core: assembles a 76-word job, holds it on the core
// inputs, waits the core latency, then streams the 128-bit result out as four words.
module blink_stream_loader
    import blink_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic             s_enc,
    output logic             s_ready,
    output logic             core_enc,
    output logic [K0_W-1:0]  core_K0,
    output logic [K1_W-1:0]  core_K1,
    output logic [N-1:0]     core_P,
    output logic [TWEAK_LEN-1:0] core_T,
    input  logic [N-1:0]     core_C,
    output logic [W-1:0]     m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             busy
);

    state_e                 state_q;
    logic [6:0]             wcnt_q;
    logic [7:0]             wait_cnt_q;
    logic [1:0]             ocnt_q;
    logic [1:0]             ocnt_nxt;
    logic [N-1:0]           res_q;
    logic                   s_ready_q, m_valid_q, m_last_q, frame_err_q, busy_q, core_enc_q;
    logic [W-1:0]           m_data_q;
    logic [K0_W-1:0]        core_k0_q;
    logic [K1_W-1:0]        core_k1_q;
    logic [N-1:0]           core_p_q;
    logic [TWEAK_LEN-1:0]   core_t_q;

    assign ocnt_nxt = ocnt_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLoad;
            wcnt_q      <= '0;
            wait_cnt_q  <= '0;
            ocnt_q      <= '0;
            res_q       <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            core_enc_q  <= 1'b0;
            core_k0_q   <= '0;
            core_k1_q   <= '0;
            core_p_q    <= '0;
            core_t_q    <= '0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    s_ready_q <= 1'b1;
                    if (s_valid && s_ready_q) begin
                        unique case (wcnt_q) inside
                            [OFF_K0:OFF_K1-7'd1]: begin
                                for (int i = 0; i < int'(NW_K0); i++) begin
                                    if (wcnt_q == OFF_K0 + 7'(i)) core_k0_q[32*i +: 32] <= s_data;
                                end
                            end
                            [OFF_K1:K1_TOP-7'd1]: begin
                                for (int i = 0; i < int'(NW_K1) - 1; i++) begin
                                    if (wcnt_q == OFF_K1 + 7'(i)) core_k1_q[32*i +: 32] <= s_data;
                                end
                            end
                            // K1 is 766 bits: the top two bits of its last word are dropped.
                            K1_TOP: core_k1_q[K1_W-1:32*(NW_K1-1)] <= s_data[29:0];
                            [OFF_P:OFF_T-7'd1]: begin
                                for (int i = 0; i < int'(NW_P); i++) begin
                                    if (wcnt_q == OFF_P + 7'(i)) core_p_q[32*i +: 32] <= s_data;
                                end
                            end
                            [OFF_T:FRAME_LAST]: begin
                                for (int i = 0; i < int'(NW_T); i++) begin
                                    if (wcnt_q == OFF_T + 7'(i)) core_t_q[32*i +: 32] <= s_data;
                                end
                            end
                            default: ;
                        endcase

                        if (wcnt_q == FRAME_LAST && s_last) begin
                            core_enc_q <= s_enc;
                            wcnt_q     <= '0;
                            wait_cnt_q <= '0;
                            s_ready_q  <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= StWait;
                        end else if (wcnt_q == FRAME_LAST || s_last) begin
                            frame_err_q <= 1'b1;
                            wcnt_q      <= '0;
                        end else begin
                            wcnt_q <= wcnt_q + 7'd1;
                        end
                    end
                end
                StWait: begin
                    // One extra cycle past LAT so C is sampled after the wrapper output reg settles.
                    if (wait_cnt_q == 8'(LAT)) begin
                        res_q     <= core_C;
                        m_data_q  <= core_C[31:0];
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        ocnt_q    <= '0;
                        state_q   <= StOut;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StOut: begin
                    if (m_ready) begin
                        if (ocnt_q == 2'd3) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            ocnt_q    <= '0;
                            busy_q    <= 1'b0;
                            s_ready_q <= 1'b1;
                            state_q   <= StLoad;
                        end else begin
                            ocnt_q   <= ocnt_nxt;
                            m_data_q <= res_q[32*ocnt_nxt +: 32];
                            m_last_q <= (ocnt_nxt == 2'd3);
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_data    = m_data_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign core_enc  = core_enc_q;
    assign core_K0   = core_k0_q;
    assign core_K1   = core_k1_q;
    assign core_P    = core_p_q;
    assign core_T    = core_t_q;

endmodule

// File: tb/tb_blink_stream_loader.sv
// Self-checking bench for blink_stream_loader with a 2-stage registered stand-in core
// computing C = P ^ T[127:0].
module tb_blink_stream_loader;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0, s_last = 1'b0, s_enc = 1'b0;
    logic          s_ready;
    logic          core_enc;
    logic [1279:0] core_K0;
    logic [765:0]  core_K1;
    logic [127:0]  core_P;
    logic [255:0]  core_T;
    logic [127:0]  core_C, stub_q;
    logic [31:0]   m_data;
    logic          m_valid, m_last;
    logic          m_ready = 1'b0;
    logic          frame_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;

    logic [31:0] fr [76];
    logic [31:0] got [4];
    logic        got_last [4];
    int          n_got;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        stub_q <= core_P ^ core_T[127:0];
        core_C <= stub_q;
    end

    always_ff @(posedge clk) if (frame_err) err_seen <= err_seen + 1;

    blink_stream_loader #(.W(32), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_enc(s_enc), .s_ready(s_ready),
        .core_enc(core_enc), .core_K0(core_K0), .core_K1(core_K1), .core_P(core_P),
        .core_T(core_T), .core_C(core_C),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frame_err(frame_err), .busy(busy)
    );

    function automatic logic [31:0] exp_c(input int j);
        return fr[64+j] ^ fr[68+j];
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 76; k++) fr[k] = $urandom;
    endtask

    // Sends words 0..nwords-1; s_last on word last_at. Timeout counts as a failure.
    task automatic send_frame(input logic enc, input int last_at, input int nwords,
                              input int gap_max);
        for (int k = 0; k < nwords; k++) begin
            int  n;
            logic rdy;
            s_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
            s_data = fr[k]; s_last = (k == last_at); s_enc = enc; s_valid = 1'b1;
            n = 0;
            do begin
                rdy = s_ready;
                @(posedge clk); #1;
                n++;
            end while (!rdy && n < 50);
            if (!rdy) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout word=%0d s_ready=%b required 1", k, rdy);
                k = nwords;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic recv_result(input int ready_pct);
        int cyc = 0;
        n_got = 0;
        while (n_got < 4 && cyc < 300) begin
            m_ready = ($urandom_range(99, 0) < ready_pct);
            if (m_valid && m_ready) begin
                got[n_got] = m_data; got_last[n_got] = m_last; n_got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({s_ready, m_valid, m_last, frame_err, busy, core_enc} !== 6'b0 || m_data !== '0 ||
            core_K0 !== '0 || core_K1 !== '0 || core_P !== '0 || core_T !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs s_ready=%b m_valid=%b busy=%b m_data=%h required all 0",
                     s_ready, m_valid, busy, m_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < 76; k++) fr[k] = 32'(k);
        send_frame(1'b1, 75, 76, 0);
        n_tests++;
        if (core_K0[31:0] !== 32'd0 || core_P[31:0] !== 32'd64 || core_enc !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fields K0lo=%h P=%h enc=%b required 0 40 1",
                     core_K0[31:0], core_P[31:0], core_enc);
        end
        n_tests++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_wait busy=%b s_ready=%b required 1 0", busy, s_ready);
        end
        recv_result(100);
        for (int j = 0; j < 4; j++) begin
            n_tests++;
            if (j >= n_got || got[j] !== exp_c(j) || got_last[j] !== (j == 3)) begin
                n_fail++;
                $display("FAIL basic_word%0d got=%h last=%b required %h last=%b",
                         j, got[j], got_last[j], exp_c(j), (j == 3));
            end
        end
        n_tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_return m_valid=%b s_ready=%b busy=%b required 0 1 0",
                     m_valid, s_ready, busy);
        end
    endtask

    task automatic test_k1_top();
        logic [767:0] k1;
        fill_random();
        fr[63] = 32'hFFFF_FFFF;
        for (int i = 0; i < 24; i++) k1[32*i +: 32] = fr[40+i];
        send_frame(1'b0, 75, 76, 1);
        n_tests++;
        if (core_K1[765:736] !== 30'h3FFF_FFFF || core_K1[735:0] !== k1[735:0]) begin
            n_fail++;
            $display("FAIL k1_top got=%h required %h", core_K1[765:736], 30'h3FFF_FFFF);
        end
        recv_result(100);
        n_tests++;
        if (n_got != 4) begin
            n_fail++; $display("FAIL k1_drain got %0d words required 4", n_got);
        end
    endtask

    task automatic test_frame_err();
        int e0 = err_seen;
        fill_random();
        send_frame(1'b0, 10, 11, 0);
        n_tests++;
        if (frame_err !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pulse frame_err=%b s_ready=%b required 1 1", frame_err, s_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL err_one_cycle frame_err=%b busy=%b required 0 0",
                               frame_err, busy);
        end
        fill_random();
        send_frame(1'b1, 75, 76, 0);
        recv_result(100);
        for (int j = 0; j < 4; j++) begin
            n_tests++;
            if (j >= n_got || got[j] !== exp_c(j)) begin
                n_fail++; $display("FAIL err_recover_word%0d got=%h required %h",
                                   j, got[j], exp_c(j));
            end
        end
        n_tests++;
        if (err_seen - e0 != 1) begin
            n_fail++; $display("FAIL err_count got %0d required 1", err_seen - e0);
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        fill_random();
        send_frame(1'b0, 75, 76, 0);
        while (!m_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== exp_c(0)) begin
            n_fail++; $display("FAIL bp_word0 valid=%b data=%h required 1 %h",
                               m_valid, m_data, exp_c(0));
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== exp_c(1) || busy !== 1'b1 || m_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold valid=%b data=%h busy=%b required 1 %h 1",
                         m_valid, m_data, busy, exp_c(1));
            end
        end
        recv_result(100);
        n_tests++;
        if (n_got != 3 || got[0] !== exp_c(1) || got[1] !== exp_c(2) || got[2] !== exp_c(3) ||
            got_last[2] !== 1'b1) begin
            n_fail++; $display("FAIL bp_rest n=%0d w=%h %h %h required 3 %h %h %h",
                               n_got, got[0], got[1], got[2], exp_c(1), exp_c(2), exp_c(3));
        end
    endtask

    task automatic test_reset_wait();
        bit seen_valid = 0;
        fill_random();
        send_frame(1'b1, 75, 76, 0);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({s_ready, m_valid, m_last, frame_err, busy, core_enc} !== 6'b0 ||
            core_K0 !== '0 || core_P !== '0 || core_T !== '0) begin
            n_fail++;
            $display("FAIL rst_wait s_ready=%b m_valid=%b busy=%b enc=%b required all 0",
                     s_ready, m_valid, busy, core_enc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_ready got %b required 1", s_ready);
        end
        repeat (8) begin
            if (m_valid) seen_valid = 1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen_valid) begin
            n_fail++; $display("FAIL rst_wait_no_output m_valid seen=1 required 0");
        end
        fill_random();
        send_frame(1'b0, 75, 76, 0);
        recv_result(100);
        n_tests++;
        if (n_got != 4 || got[0] !== exp_c(0) || got[3] !== exp_c(3)) begin
            n_fail++; $display("FAIL rst_wait_next n=%0d w0=%h required 4 %h",
                               n_got, got[0], exp_c(0));
        end
    endtask

    task automatic test_back_to_back();
        int e0 = err_seen;
        for (int f = 0; f < 50; f++) begin
            logic [1279:0] k0;
            logic [767:0]  k1;
            logic [127:0]  p;
            logic [255:0]  t;
            logic          enc;
            bit            bad;
            fill_random();
            enc = 1'($urandom);
            for (int i = 0; i < 40; i++) k0[32*i +: 32] = fr[i];
            for (int i = 0; i < 24; i++) k1[32*i +: 32] = fr[40+i];
            for (int i = 0; i < 4; i++)  p[32*i +: 32]  = fr[64+i];
            for (int i = 0; i < 8; i++)  t[32*i +: 32]  = fr[68+i];
            send_frame(enc, 75, 76, 3);
            n_tests++;
            if (core_K0 !== k0 || core_K1 !== k1[765:0] || core_P !== p || core_T !== t ||
                core_enc !== enc) begin
                n_fail++; $display("FAIL b2b_fields frame=%0d P=%h required %h", f, core_P, p);
            end
            recv_result(50);
            bad = (n_got != 4);
            for (int j = 0; j < n_got; j++)
                if (got[j] !== (p[32*j +: 32] ^ t[32*j +: 32]) || got_last[j] !== (j == 3))
                    bad = 1;
            n_tests++;
            if (bad) begin
                n_fail++; $display("FAIL b2b_result frame=%0d n=%0d w0=%h required 4 %h",
                                   f, n_got, got[0], p[31:0] ^ t[31:0]);
            end
        end
        n_tests++;
        if (err_seen != e0) begin
            n_fail++; $display("FAIL b2b_frame_err got %0d required 0", err_seen - e0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_k1_top();
        test_frame_err();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
